// File: rtl/matrix_scan_driver.sv
// Scan controller for a 32x16, 1/8-scan RGB LED matrix: walks columns and rows,
// shifts pixels out on sclk, latches each row, gates brightness with oe_n.
//
// state   | meaning
// IDLE    | panel blanked, waiting for enable
// SHIFT   | 32 columns x 4 phases, sclk high in phases 2-3
// LATCH   | one-cycle lat strobe, row address captured
// DISPLAY | oe_n low for OE_HOLD cycles, row/frame/offset bookkeeping at the end
module matrix_scan_driver #(
  parameter int OE_HOLD         = 64,
  parameter int FRAMES_PER_STEP = 4,
  parameter int OFFSET_MAX      = 1023
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [2:0] LED_Top,
  input  logic [2:0] LED_Bottom,
  output logic [4:0] col_count,
  output logic [2:0] row_count,
  output logic [9:0] offset,
  output logic [2:0] rgb_top,
  output logic [2:0] rgb_bottom,
  output logic       sclk,
  output logic       lat,
  output logic       oe_n,
  output logic [2:0] addr,
  output logic       frame_done
);

  localparam int TMR_W = (OE_HOLD > 1) ? $clog2(OE_HOLD) : 1;
  localparam int FRM_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(OE_HOLD - 1);
  localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(FRAMES_PER_STEP - 1);
  localparam logic [9:0]       OFF_LAST = 10'(OFFSET_MAX);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SHIFT   = 2'd1,
    ST_LATCH   = 2'd2,
    ST_DISPLAY = 2'd3
  } state_t;

  state_t           state, state_d;
  logic [1:0]       phase, phase_d;
  logic [TMR_W-1:0] tmr, tmr_d;
  logic [FRM_W-1:0] frm_cnt, frm_cnt_d;
  logic [4:0]       col_d;
  logic [2:0]       row_d;
  logic [9:0]       offset_d;
  logic [2:0]       rgb_top_d, rgb_bottom_d;
  logic [2:0]       addr_d;
  logic             sclk_d, lat_d, oe_n_d, frame_done_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      phase      <= 2'd0;
      tmr        <= '0;
      frm_cnt    <= '0;
      col_count  <= 5'd0;
      row_count  <= 3'd0;
      offset     <= 10'd0;
      rgb_top    <= 3'd0;
      rgb_bottom <= 3'd0;
      addr       <= 3'd0;
      sclk       <= 1'b0;
      lat        <= 1'b0;
      oe_n       <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      state      <= state_d;
      phase      <= phase_d;
      tmr        <= tmr_d;
      frm_cnt    <= frm_cnt_d;
      col_count  <= col_d;
      row_count  <= row_d;
      offset     <= offset_d;
      rgb_top    <= rgb_top_d;
      rgb_bottom <= rgb_bottom_d;
      addr       <= addr_d;
      sclk       <= sclk_d;
      lat        <= lat_d;
      oe_n       <= oe_n_d;
      frame_done <= frame_done_d;
    end
  end

  always_comb begin
    state_d      = state;
    phase_d      = phase;
    tmr_d        = tmr;
    frm_cnt_d    = frm_cnt;
    col_d        = col_count;
    row_d        = row_count;
    offset_d     = offset;
    rgb_top_d    = rgb_top;
    rgb_bottom_d = rgb_bottom;
    addr_d       = addr;
    frame_done_d = 1'b0;

    case (state)
      ST_IDLE: begin
        if (enable) begin
          state_d = ST_SHIFT;
          phase_d = 2'd0;
          col_d   = 5'd0;
        end
      end

      ST_SHIFT: begin
        phase_d = phase + 2'd1;
        // LED_* lags col_count by one clk, so the pixel for this column is present in P1
        if (phase == 2'd1) begin
          rgb_top_d    = LED_Top;
          rgb_bottom_d = LED_Bottom;
        end
        if (phase == 2'd3) begin
          if (col_count == 5'd31) begin
            col_d   = 5'd0;
            state_d = ST_LATCH;
          end else begin
            col_d = col_count + 5'd1;
          end
        end
      end

      ST_LATCH: begin
        addr_d  = row_count;
        tmr_d   = TMR_LOAD;
        state_d = ST_DISPLAY;
      end

      ST_DISPLAY: begin
        if (tmr == '0) begin
          row_d = row_count + 3'd1;
          if (row_count == 3'd7) begin
            frame_done_d = 1'b1;
            if (frm_cnt == FRM_LAST) begin
              frm_cnt_d = '0;
              offset_d  = (offset == OFF_LAST) ? 10'd0 : offset + 10'd1;
            end else begin
              frm_cnt_d = frm_cnt + 1'b1;
            end
          end
          if (enable) begin
            state_d = ST_SHIFT;
            phase_d = 2'd0;
          end else begin
            state_d = ST_IDLE;
            row_d   = 3'd0;
          end
        end else begin
          tmr_d = tmr - 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // panel strobes are registered from the next state so they are glitch-free
    sclk_d = (state_d == ST_SHIFT) && phase_d[1];
    lat_d  = (state_d == ST_LATCH);
    oe_n_d = (state_d != ST_DISPLAY);
  end

endmodule

// File: tb/tb_matrix_scan_driver.sv
// Scoreboard bench for matrix_scan_driver: a frame-level model queues the expected
// pixels, latched rows and frame offsets; a monitor checks them as the panel strobes appear.
module tb_matrix_scan_driver;

  localparam int OE_HOLD = 64;
  localparam int FPS     = 4;
  localparam int OMAX    = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [2:0] LED_Top, LED_Bottom;
  logic [4:0] col_count;
  logic [2:0] row_count;
  logic [9:0] offset;
  logic [2:0] rgb_top, rgb_bottom;
  logic       sclk, lat, oe_n, frame_done;
  logic [2:0] addr;

  matrix_scan_driver #(.OE_HOLD(OE_HOLD), .FRAMES_PER_STEP(FPS), .OFFSET_MAX(OMAX)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .LED_Top(LED_Top), .LED_Bottom(LED_Bottom),
    .col_count(col_count), .row_count(row_count), .offset(offset),
    .rgb_top(rgb_top), .rgb_bottom(rgb_bottom),
    .sclk(sclk), .lat(lat), .oe_n(oe_n), .addr(addr), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(string name, longint act, longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // random picture content, indexed row*32+col
  logic [2:0] tbl_top [256];
  logic [2:0] tbl_bot [256];

  // upstream pixel source: one clk of latency from indices to LED_*
  initial begin
    logic [4:0] c_s;
    logic [2:0] r_s;
    logic [9:0] o_s;
    LED_Top = 3'd0;
    LED_Bottom = 3'd0;
    forever begin
      @(negedge clk);
      c_s = col_count; r_s = row_count; o_s = offset;
      @(posedge clk);
      #1;
      LED_Top    = tbl_top[{r_s, c_s}] ^ o_s[2:0];
      LED_Bottom = tbl_bot[{r_s, c_s}] ^ o_s[2:0];
    end
  end

  // reference model: expectations derived from frame arithmetic
  logic [5:0] q_pix[$];
  int         q_lat[$];
  logic [9:0] q_fd[$];
  int         k_done = 0;

  function automatic logic [9:0] model_offset(int k);
    return 10'((k / FPS) % (OMAX + 1));
  endfunction

  task automatic push_row(int r);
    logic [9:0] o;
    o = model_offset(k_done);
    for (int c = 0; c < 32; c++)
      q_pix.push_back({tbl_top[r*32+c] ^ o[2:0], tbl_bot[r*32+c] ^ o[2:0]});
    q_lat.push_back(r);
  endtask

  task automatic push_frame();
    for (int r = 0; r < 8; r++) push_row(r);
    k_done++;
    q_fd.push_back(model_offset(k_done));
  endtask

  // monitor
  int n_lat = 0, n_fd = 0;
  int cyc = 0, first_sclk_cyc = -1, lat_cyc = 0, oe_start = 0, fd_cyc = 0;
  int sclk_in_row = 0, lat_row = 0;
  logic p_sclk = 0, p_lat = 0, p_oe = 1, p_fd = 0;

  initial begin
    logic [5:0] exp_pix;
    logic [9:0] exp_off;
    forever begin
      @(posedge clk);
      #1;
      if (!reset) begin
        p_sclk = 0; p_lat = 0; p_oe = 1; p_fd = 0;
        sclk_in_row = 0;
      end else begin
        cyc++;
        if (sclk && !p_sclk) begin
          if (first_sclk_cyc < 0) first_sclk_cyc = cyc;
          sclk_in_row++;
          if (q_pix.size() == 0) check("pix_unexpected", 1, 0);
          else begin
            exp_pix = q_pix.pop_front();
            check("pix_rgb", {rgb_top, rgb_bottom}, exp_pix);
          end
        end
        if (lat && !p_lat) begin
          n_lat++;
          lat_cyc = cyc;
          check("sclk_per_row", sclk_in_row, 32);
          sclk_in_row = 0;
          if (n_lat == 1) check("first_lat_time", lat_cyc - first_sclk_cyc, 126);
          if (q_lat.size() == 0) check("lat_unexpected", 1, 0);
          else begin
            lat_row = q_lat.pop_front();
            check("lat_row", row_count, lat_row);
          end
        end
        if (!lat && p_lat) check("lat_width", cyc - lat_cyc, 1);
        if (!oe_n && p_oe) begin
          oe_start = cyc;
          check("oe_after_lat", cyc - lat_cyc, 1);
          check("addr", addr, lat_row);
        end
        if (oe_n && !p_oe) check("oe_low_len", cyc - oe_start, OE_HOLD);
        if (frame_done && !p_fd) begin
          n_fd++;
          fd_cyc = cyc;
          if (n_fd == 1) check("first_frame_time", fd_cyc - first_sclk_cyc, 1542);
          check("fd_row_count", row_count, 0);
          if (q_fd.size() == 0) check("fd_unexpected", 1, 0);
          else begin
            exp_off = q_fd.pop_front();
            check("fd_offset", offset, exp_off);
          end
        end
        if (!frame_done && p_fd) check("fd_width", cyc - fd_cyc, 1);
        p_sclk = sclk; p_lat = lat; p_oe = oe_n; p_fd = frame_done;
      end
    end
  end

  task automatic wait_lat(int target, int budget);
    int i = 0;
    while (n_lat < target && i < budget) begin @(posedge clk); #2; i++; end
    check("wait_lat", n_lat, target);
  endtask

  task automatic wait_fd(int target, int budget);
    int i = 0;
    while (n_fd < target && i < budget) begin @(posedge clk); #2; i++; end
    check("wait_frame_done", n_fd, target);
  endtask

  task automatic wait_oe(logic val, int budget);
    int i = 0;
    while (oe_n != val && i < budget) begin @(posedge clk); #2; i++; end
    check("wait_oe_n", oe_n, val);
  endtask

  initial begin
    int n, hi;
    for (int i = 0; i < 256; i++) begin
      tbl_top[i] = 3'($urandom_range(0, 7));
      tbl_bot[i] = 3'($urandom_range(0, 7));
    end
    reset  = 1'b0;
    enable = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check("rst_col", col_count, 0);
    check("rst_row", row_count, 0);
    check("rst_offset", offset, 0);
    check("rst_rgb", {rgb_top, rgb_bottom}, 0);
    check("rst_addr", addr, 0);
    check("rst_strobes", {sclk, lat, frame_done}, 0);
    check("rst_oe_n", oe_n, 1);

    // 9 full frames, then rows 0..3 of the 10th before enable drops
    for (int f = 0; f < 9; f++) push_frame();
    for (int r = 0; r < 4; r++) push_row(r);

    @(negedge clk);
    reset = 1'b1;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #2; n++;
      if (sclk) break;
    end
    check("first_sclk_delay", n, 3);
    check("first_sclk_col", col_count, 0);

    wait_lat(75, 20000);
    repeat (OE_HOLD + 20) @(posedge clk);
    @(negedge clk);
    enable = 1'b0;
    wait_lat(76, 400);
    wait_oe(1'b0, 100);
    wait_oe(1'b1, 200);
    hi = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #2;
      if (sclk || !oe_n) hi++;
    end
    check("idle_quiet", hi, 0);
    check("idle_row", row_count, 0);
    check("idle_offset", offset, model_offset(9));
    check("idle_frames", n_fd, 9);
    check("idle_lats", n_lat, 76);

    // restart: the partial frame does not count, offset and frame counter resume
    for (int f = 0; f < 7; f++) push_frame();
    push_row(0);
    @(negedge clk);
    enable = 1'b1;
    wait_fd(16, 7 * 1544 + 600);
    wait_lat(133, 400);
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("pre_reset_oe_n", oe_n, 0);
    check("pre_reset_offset", offset, model_offset(16));
    reset  = 1'b0;
    enable = 1'b0;
    #1;
    check("async_oe_n", oe_n, 1);
    check("async_idx", {col_count, row_count, offset}, 0);
    check("async_strobes", {sclk, lat}, 0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    hi = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #2;
      if (sclk || !oe_n) hi++;
    end
    check("post_reset_idle", hi, 0);
    check("q_pix_empty", q_pix.size(), 0);
    check("q_lat_empty", q_lat.size(), 0);
    check("q_fd_empty", q_fd.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
